// File: rtl/ct_dec_crt.sv
// RSA-CRT decryption core: constant-time right-to-left modexp on both prime
// chains in parallel, then Garner recombination M = mq + q*(qinv*(mp-mq) mod p).
module ct_dec_crt (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [31:0] C,
    input  logic [15:0] p,
    input  logic [15:0] q,
    input  logic [15:0] dp,
    input  logic [15:0] dq,
    input  logic [15:0] qinv,
    output logic [31:0] M,
    output logic        done_decrypt,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, REDUCE, EXP, COMB1, COMB2, FINISH} state_t;

    state_t      state, state_n;
    logic [31:0] c_r;
    logic [15:0] p_r, q_r, dp_r, dq_r, qinv_r;
    logic [15:0] bp, bq, accp, accq, h;
    logic [3:0]  cnt;
    logic        bad;

    // Full 32-bit product is reduced before narrowing; nothing is truncated early.
    function automatic logic [15:0] mulmod(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] m);
        logic [31:0] prod;
        prod   = {16'd0, a} * {16'd0, b};
        mulmod = 16'(prod % {16'd0, m});
    endfunction

    logic [15:0] aqp, tdiff;
    logic [16:0] diff;

    // accp + p - (accq mod p) lies in [1, 2p), so 17 bits cover it.
    assign aqp   = accq % p_r;
    assign diff  = {1'b0, accp} + {1'b0, p_r} - {1'b0, aqp};
    assign tdiff = 16'({15'd0, diff} % {16'd0, p_r});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (done) state_n = REDUCE;
            REDUCE:  state_n = bad ? FINISH : EXP;
            EXP:     if (cnt == 4'd15) state_n = COMB1;
            COMB1:   state_n = COMB2;
            COMB2:   state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_r <= '0; p_r <= '0; q_r <= '0; dp_r <= '0; dq_r <= '0; qinv_r <= '0;
            bp <= '0; bq <= '0; accp <= '0; accq <= '0; h <= '0;
            cnt <= '0; bad <= 1'b0;
            M <= '0; done_decrypt <= 1'b0; busy <= 1'b0; err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (done) begin
                    c_r    <= C;
                    p_r    <= p;
                    q_r    <= q;
                    dp_r   <= dp;
                    dq_r   <= dq;
                    qinv_r <= qinv;
                    bad    <= (p < 16'd2) || (q < 16'd2);
                    busy   <= 1'b1;
                end
                REDUCE: begin
                    // Degenerate modulus publishes its result here so it never touches a mod-by-<2.
                    if (bad) begin
                        M            <= '0;
                        err          <= 1'b1;
                        done_decrypt <= 1'b1;
                    end else begin
                        bp   <= 16'(c_r % {16'd0, p_r});
                        bq   <= 16'(c_r % {16'd0, q_r});
                        accp <= 16'd1;
                        accq <= 16'd1;
                        cnt  <= '0;
                    end
                end
                EXP: begin
                    if (dp_r[cnt]) accp <= mulmod(accp, bp, p_r);
                    if (dq_r[cnt]) accq <= mulmod(accq, bq, q_r);
                    bp  <= mulmod(bp, bp, p_r);
                    bq  <= mulmod(bq, bq, q_r);
                    cnt <= cnt + 4'd1;
                end
                COMB1: h <= mulmod(qinv_r, tdiff, p_r);
                COMB2: begin
                    M            <= {16'd0, accq} + ({16'd0, h} * {16'd0, q_r});
                    err          <= 1'b0;
                    done_decrypt <= 1'b1;
                end
                FINISH: begin
                    done_decrypt <= 1'b0;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
